// File: rtl/lcd_tile_streamer.sv
// Init-script player and tile window streamer feeding an 8080-style LCD bus FIFO.
// Optional build macro LCD_TE_SYNC_EN adds lcd_te and holds each frame's first tile for a tearing-effect edge.
module lcd_tile_streamer #(
    parameter int TILE_W      = 32,
    parameter int TILE_H      = 32,
    parameter int TILES_X     = 10,
    parameter int TILES_Y     = 8,
    parameter int LAST_TILE_H = 16,
    parameter int INIT_AW     = 7,
    parameter int DELAY_SHIFT = 16,
    localparam int XW = (TILES_X > 1) ? $clog2(TILES_X) : 1,
    localparam int YW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1,
    localparam int AW = $clog2(TILE_W * TILE_H)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [INIT_AW-1:0] init_addr,
    input  logic [8:0]         init_data,
    input  logic [XW-1:0]      tile_x,
    input  logic [YW-1:0]      tile_y,
    input  logic               tile_ready,
    output logic [AW-1:0]      tile_addr,
    input  logic [15:0]        tile_data,
    output logic               tile_next,
    output logic [8:0]         cmd_data,
    output logic               cmd_valid,
    input  logic               cmd_pull,
    input  logic               lcd_ready,
`ifdef LCD_TE_SYNC_EN
    input  logic               lcd_te,
`endif
    output logic               lcd_rst,
    output logic               init_done
);

    localparam int DLW = 8 + DELAY_SHIFT;
    localparam logic [8:0] WORD_NOP   = 9'h100;
    localparam logic [8:0] CMD_CASET  = 9'h12A;
    localparam logic [8:0] CMD_PASET  = 9'h12B;
    localparam logic [8:0] CMD_RAMWR  = 9'h12C;

    typedef enum logic [4:0] {
        S_INIT_FETCH, S_INIT_DECODE, S_INIT_OUT, S_WAIT_TILE,
        S_CAS, S_SCH, S_SCL, S_ECH, S_ECL,
        S_PAS, S_SPH, S_SPL, S_EPH, S_EPL,
        S_RAMWR, S_PIX_LD, S_PIXH, S_PIXL
    } state_t;

    state_t             state_q, state_d;
    logic [INIT_AW-1:0] init_addr_q, init_addr_d;
    logic [DLW-1:0]     delay_q, delay_d;
    logic               arg_pending_q, arg_pending_d;
    logic               lcd_rst_q, lcd_rst_d;
    logic               init_done_q, init_done_d;
    logic [8:0]         cmd_data_q, cmd_data_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [AW-1:0]      tile_addr_q, tile_addr_d;
    logic               tile_next_q, tile_next_d;
    logic [XW-1:0]      tx_q, tx_d;
    logic [YW-1:0]      ty_q, ty_d;

    logic               pull;
    logic               advance;
    logic               tile_go;
    logic               last_row;
    logic [15:0]        sc, ec, sp, ep;
    logic [AW-1:0]      last_pix;

    assign pull     = cmd_valid_q & cmd_pull;
    assign last_row = (ty_q == YW'(TILES_Y - 1));
    assign sc       = 16'(32'(tx_q) * TILE_W);
    assign ec       = sc + 16'(TILE_W - 1);
    assign sp       = 16'(32'(ty_q) * TILE_H);
    assign ep       = sp + (last_row ? 16'(LAST_TILE_H - 1) : 16'(TILE_H - 1));
    assign last_pix = last_row ? AW'(TILE_W * LAST_TILE_H - 1) : AW'(TILE_W * TILE_H - 1);

`ifdef LCD_TE_SYNC_EN
    logic te_meta_q, te_meta_d;
    logic te_sync_q, te_sync_d;
    logic te_prev_q, te_prev_d;
    logic te_seen_q, te_seen_d;
    logic te_rise;
    logic frame_start;

    assign te_rise     = te_sync_q & ~te_prev_q;
    assign frame_start = (tile_x == '0) && (tile_y == '0);
    assign tile_go     = tile_ready && (!frame_start || te_seen_q || te_rise);

    // Only edges arriving while idle between tiles count; edges during streaming are dropped.
    always_comb begin
        te_meta_d = lcd_te;
        te_sync_d = te_meta_q;
        te_prev_d = te_sync_q;
        te_seen_d = (state_q == S_WAIT_TILE) && !tile_go && (te_seen_q || te_rise);
    end
`else
    assign tile_go = tile_ready;
`endif

    always_comb begin
        state_d       = state_q;
        init_addr_d   = init_addr_q;
        delay_d       = (delay_q == '0) ? '0 : delay_q - DLW'(1);
        arg_pending_d = arg_pending_q;
        lcd_rst_d     = lcd_rst_q;
        init_done_d   = init_done_q;
        cmd_data_d    = cmd_data_q;
        cmd_valid_d   = cmd_valid_q;
        tile_addr_d   = tile_addr_q;
        tile_next_d   = 1'b0;
        tx_d          = tx_q;
        ty_d          = ty_q;
        advance       = 1'b0;

        case (state_q)
            // Every script step, opcodes included, waits out a pending delay and a busy bus.
            S_INIT_FETCH: if (delay_q == '0 && lcd_ready) state_d = S_INIT_DECODE;
            S_INIT_DECODE: begin
                if (arg_pending_q) begin
                    delay_d       = DLW'(init_data[7:0]) << DELAY_SHIFT;
                    arg_pending_d = 1'b0;
                    advance       = 1'b1;
                end else begin
                    case (init_data)
                        9'h1FD: begin lcd_rst_d = 1'b1; advance = 1'b1; end
                        9'h1FE: begin lcd_rst_d = 1'b0; advance = 1'b1; end
                        9'h1FF: begin arg_pending_d = 1'b1; advance = 1'b1; end
                        9'h1FC: begin init_done_d = 1'b1; state_d = S_WAIT_TILE; end
                        9'h100: advance = 1'b1;
                        default: begin
                            cmd_data_d  = init_data;
                            cmd_valid_d = 1'b1;
                            state_d     = S_INIT_OUT;
                        end
                    endcase
                end
            end
            S_INIT_OUT: if (pull) begin
                cmd_valid_d = 1'b0;
                cmd_data_d  = WORD_NOP;
                advance     = 1'b1;
            end
            S_WAIT_TILE: if (tile_go) begin
                tx_d        = tile_x;
                ty_d        = tile_y;
                cmd_data_d  = CMD_CASET;
                cmd_valid_d = 1'b1;
                state_d     = S_CAS;
            end
            S_CAS: if (pull) begin cmd_data_d = {1'b0, sc[15:8]}; state_d = S_SCH; end
            S_SCH: if (pull) begin cmd_data_d = {1'b0, sc[7:0]};  state_d = S_SCL; end
            S_SCL: if (pull) begin cmd_data_d = {1'b0, ec[15:8]}; state_d = S_ECH; end
            S_ECH: if (pull) begin cmd_data_d = {1'b0, ec[7:0]};  state_d = S_ECL; end
            S_ECL: if (pull) begin cmd_data_d = CMD_PASET;        state_d = S_PAS; end
            S_PAS: if (pull) begin cmd_data_d = {1'b0, sp[15:8]}; state_d = S_SPH; end
            S_SPH: if (pull) begin cmd_data_d = {1'b0, sp[7:0]};  state_d = S_SPL; end
            S_SPL: if (pull) begin cmd_data_d = {1'b0, ep[15:8]}; state_d = S_EPH; end
            S_EPH: if (pull) begin cmd_data_d = {1'b0, ep[7:0]};  state_d = S_EPL; end
            S_EPL: if (pull) begin cmd_data_d = CMD_RAMWR;        state_d = S_RAMWR; end
            S_RAMWR: if (pull) begin
                cmd_valid_d = 1'b0;
                cmd_data_d  = WORD_NOP;
                state_d     = S_PIX_LD;
            end
            // tile_data follows the registered tile_addr, so each pixel needs one load cycle.
            S_PIX_LD: begin
                cmd_data_d  = {1'b0, tile_data[15:8]};
                cmd_valid_d = 1'b1;
                state_d     = S_PIXH;
            end
            S_PIXH: if (pull) begin cmd_data_d = {1'b0, tile_data[7:0]}; state_d = S_PIXL; end
            S_PIXL: if (pull) begin
                cmd_valid_d = 1'b0;
                cmd_data_d  = WORD_NOP;
                if (tile_addr_q == last_pix) begin
                    tile_addr_d = '0;
                    tile_next_d = 1'b1;
                    state_d     = S_WAIT_TILE;
                end else begin
                    tile_addr_d = tile_addr_q + AW'(1);
                    state_d     = S_PIX_LD;
                end
            end
            default: state_d = S_INIT_FETCH;
        endcase

        if (advance) begin
            init_addr_d = init_addr_q + INIT_AW'(1);
            if (init_addr_q == '1) begin
                init_done_d = 1'b1;
                state_d     = S_WAIT_TILE;
            end else begin
                state_d = S_INIT_FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT_FETCH;
            init_addr_q   <= '0;
            delay_q       <= '0;
            arg_pending_q <= 1'b0;
            lcd_rst_q     <= 1'b0;
            init_done_q   <= 1'b0;
            cmd_data_q    <= WORD_NOP;
            cmd_valid_q   <= 1'b0;
            tile_addr_q   <= '0;
            tile_next_q   <= 1'b0;
            tx_q          <= '0;
            ty_q          <= '0;
`ifdef LCD_TE_SYNC_EN
            te_meta_q     <= 1'b0;
            te_sync_q     <= 1'b0;
            te_prev_q     <= 1'b0;
            te_seen_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            init_addr_q   <= init_addr_d;
            delay_q       <= delay_d;
            arg_pending_q <= arg_pending_d;
            lcd_rst_q     <= lcd_rst_d;
            init_done_q   <= init_done_d;
            cmd_data_q    <= cmd_data_d;
            cmd_valid_q   <= cmd_valid_d;
            tile_addr_q   <= tile_addr_d;
            tile_next_q   <= tile_next_d;
            tx_q          <= tx_d;
            ty_q          <= ty_d;
`ifdef LCD_TE_SYNC_EN
            te_meta_q     <= te_meta_d;
            te_sync_q     <= te_sync_d;
            te_prev_q     <= te_prev_d;
            te_seen_q     <= te_seen_d;
`endif
        end
    end

    assign init_addr = init_addr_q;
    assign tile_addr = tile_addr_q;
    assign tile_next = tile_next_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign lcd_rst   = lcd_rst_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_tile_streamer.sv
// Directed bench for lcd_tile_streamer: init scripts, tile windows, stalls and mid-tile reset.
// DELAY_SHIFT is reduced to 4 so script delays stay short.
module tb_lcd_tile_streamer;

    localparam int DSH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  init_addr;
    logic [8:0]  init_data;
    logic [3:0]  tile_x;
    logic [2:0]  tile_y;
    logic        tile_ready;
    logic [9:0]  tile_addr;
    logic [15:0] tile_data;
    logic        tile_next;
    logic [8:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_pull;
    logic        lcd_ready;
    logic        lcd_rst;
    logic        init_done;
`ifdef LCD_TE_SYNC_EN
    logic        lcd_te;
`endif

    always #5 clk = ~clk;

    lcd_tile_streamer #(.DELAY_SHIFT(DSH)) dut (
        .clk(clk), .rst(rst),
        .init_addr(init_addr), .init_data(init_data),
        .tile_x(tile_x), .tile_y(tile_y), .tile_ready(tile_ready),
        .tile_addr(tile_addr), .tile_data(tile_data), .tile_next(tile_next),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_pull(cmd_pull),
        .lcd_ready(lcd_ready),
`ifdef LCD_TE_SYNC_EN
        .lcd_te(lcd_te),
`endif
        .lcd_rst(lcd_rst), .init_done(init_done)
    );

    logic [8:0] rom [0:127];
    logic [8:0] rom_q;
    always @(posedge clk) rom_q <= rom[init_addr];
    assign init_data = rom_q;

    function automatic logic [15:0] pix(input logic [9:0] a);
        logic [15:0] w;
        w[15:8] = a[9:2] ^ 8'hC3;
        w[7:0]  = a[7:0];
        return w;
    endfunction
    assign tile_data = pix(tile_addr);

    int n_vec = 0;
    int n_bad = 0;

    logic [8:0] init_words[$];
    int         rst_rise, first_valid, opcode_seen;
    logic       boot_ok;
    logic [8:0] got[$];
    logic       saw_next;
    int         max_addr, addr_err;

    task automatic fill_rom();
        for (int i = 0; i < 128; i++) rom[i] = 9'h100;
    endtask

    task automatic hard_reset();
        rst = 1'b1; cmd_pull = 1'b0; tile_ready = 1'b0; lcd_ready = 1'b1;
        tile_x = '0; tile_y = '0;
`ifdef LCD_TE_SYNC_EN
        lcd_te = 1'b0;
`endif
        got.delete(); saw_next = 1'b0; max_addr = -1; addr_err = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic boot(input int max_cyc);
        int c;
        c = 0;
        init_words.delete(); rst_rise = -1; first_valid = -1; opcode_seen = 0;
        cmd_pull = 1'b1; rst = 1'b0;
        while (c < max_cyc && !init_done) begin
            @(posedge clk); #1; c++;
            if (lcd_rst && rst_rise < 0) rst_rise = c;
            if (cmd_valid) begin
                if (first_valid < 0) first_valid = c;
                if (cmd_data[8] && (cmd_data[7:0] >= 8'hFC || cmd_data[7:0] == 8'h00)) opcode_seen++;
                init_words.push_back(cmd_data);
            end
        end
        boot_ok = init_done;
    endtask

    // Pulls a word only when it is recorded, so a stop leaves nothing half-consumed.
    task automatic pump(input int stop_words, input int max_cyc);
        int c;
        c = 0;
        while (!saw_next && got.size() < stop_words && c < max_cyc) begin
            @(posedge clk); #1; c++;
            cmd_pull = 1'b0;
            if (tile_next) begin
                saw_next = 1'b1;
                tile_ready = 1'b0;
            end else if (cmd_valid && got.size() < stop_words) begin
                if (got.size() >= 11) begin
                    if (int'(tile_addr) > max_addr) max_addr = int'(tile_addr);
                    if (int'(tile_addr) != (got.size() - 11) / 2) addr_err++;
                end
                got.push_back(cmd_data);
                cmd_pull = 1'b1;
            end
        end
    endtask

    task automatic scan_pixels(output int bytes, output int errs);
        logic [15:0] w;
        logic [8:0]  e;
        bytes = 0; errs = 0;
        for (int i = 11; i < got.size(); i++) begin
            w = pix(10'((i - 11) / 2));
            e = ((i - 11) % 2 == 0) ? {1'b0, w[15:8]} : {1'b0, w[7:0]};
            if (got[i] !== e) errs++;
            bytes++;
        end
    endtask

    task automatic test_reset();
        hard_reset();
        n_vec++; if (cmd_data !== 9'h100) begin n_bad++; $display("FAIL rst_cmd_data got %h want 100", cmd_data); end
        n_vec++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_valid got %b want 0", cmd_valid); end
        n_vec++; if (lcd_rst !== 1'b0) begin n_bad++; $display("FAIL rst_lcd_rst got %b want 0", lcd_rst); end
        n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done got %b want 0", init_done); end
        n_vec++; if (tile_next !== 1'b0 || tile_addr !== 10'd0) begin n_bad++; $display("FAIL rst_tile got next=%b addr=%0d want 0/0", tile_next, tile_addr); end
        n_vec++; if (init_addr !== 7'd0) begin n_bad++; $display("FAIL rst_init_addr got %0d want 0", init_addr); end
    endtask

    task automatic test_init_script();
        hard_reset(); fill_rom();
        rom[0] = 9'h1FE; rom[1] = 9'h1FF; rom[2] = 9'h002; rom[3] = 9'h1FD; rom[4] = 9'h011; rom[5] = 9'h1FC;
        boot(400);
        n_vec++; if (boot_ok !== 1'b1) begin n_bad++; $display("FAIL script_done got %b want 1", boot_ok); end
        n_vec++; if (init_words.size() != 1 || init_words[0] !== 9'h011) begin n_bad++; $display("FAIL script_words got n=%0d first=%h want 1 word 011", init_words.size(), init_words.size() > 0 ? init_words[0] : 9'h000); end
        n_vec++; if (opcode_seen != 0) begin n_bad++; $display("FAIL script_opcode_leak got %0d want 0", opcode_seen); end
        n_vec++; if (rst_rise < 32 || rst_rise > 50) begin n_bad++; $display("FAIL script_rst_delay got %0d want 32..50", rst_rise); end
        n_vec++; if (first_valid <= rst_rise) begin n_bad++; $display("FAIL script_order got word@%0d rst@%0d want word after rst", first_valid, rst_rise); end
        n_vec++; if (lcd_rst !== 1'b1) begin n_bad++; $display("FAIL script_lcd_rst got %b want 1", lcd_rst); end
    endtask

    task automatic test_zero_delay();
        hard_reset(); fill_rom();
        rom[0] = 9'h1FF; rom[1] = 9'h000; rom[2] = 9'h055; rom[3] = 9'h1FC;
        boot(50);
        n_vec++; if (boot_ok !== 1'b1 || init_words.size() != 1 || init_words[0] !== 9'h055) begin n_bad++; $display("FAIL zdelay_words got done=%b n=%0d want done, 1 word 055", boot_ok, init_words.size()); end
        n_vec++; if (first_valid <= 4 || first_valid > 7) begin n_bad++; $display("FAIL zdelay_latency got %0d want 5..7", first_valid); end
    endtask

    task automatic test_wrap_and_ready();
        hard_reset(); fill_rom();
        lcd_ready = 1'b0; rst = 1'b0; cmd_pull = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        n_vec++; if (init_addr !== 7'd0 || cmd_valid !== 1'b0) begin n_bad++; $display("FAIL ready_stall got addr=%0d valid=%b want 0/0", init_addr, cmd_valid); end
        lcd_ready = 1'b1;
        boot(400);
        n_vec++; if (boot_ok !== 1'b1 || init_words.size() != 0) begin n_bad++; $display("FAIL wrap_done got done=%b words=%0d want 1/0", boot_ok, init_words.size()); end
        n_vec++; if (init_addr !== 7'd0) begin n_bad++; $display("FAIL wrap_addr got %0d want 0", init_addr); end
    endtask

    task automatic check_tile(input string nm, input logic [8:0] hdr [11], input int want_bytes);
        int bytes, errs, extra;
        for (int k = 0; k < 11; k++) begin
            n_vec++; if (got[k] !== hdr[k]) begin n_bad++; $display("FAIL %s_hdr%0d got %h want %h", nm, k, got[k], hdr[k]); end
        end
        n_vec++; if (saw_next !== 1'b1) begin n_bad++; $display("FAIL %s_tile_next got %b want 1 (timeout)", nm, saw_next); end
        scan_pixels(bytes, errs);
        n_vec++; if (bytes != want_bytes) begin n_bad++; $display("FAIL %s_bytes got %0d want %0d", nm, bytes, want_bytes); end
        n_vec++; if (errs != 0) begin n_bad++; $display("FAIL %s_pixels got %0d bad want 0", nm, errs); end
        n_vec++; if (addr_err != 0 || max_addr != want_bytes / 2 - 1) begin n_bad++; $display("FAIL %s_addr got err=%0d max=%0d want 0/%0d", nm, addr_err, max_addr, want_bytes / 2 - 1); end
        extra = 0;
        repeat (6) begin @(posedge clk); #1; if (tile_next) extra++; end
        n_vec++; if (extra != 0 || tile_addr !== 10'd0 || cmd_valid !== 1'b0) begin n_bad++; $display("FAIL %s_after got pulses=%0d addr=%0d valid=%b want 0/0/0", nm, extra, tile_addr, cmd_valid); end
    endtask

    task automatic test_tile_window();
        logic [8:0] hdr [11];
        hard_reset(); fill_rom(); rom[0] = 9'h1FC;
        boot(20);
        n_vec++; if (boot_ok !== 1'b1) begin n_bad++; $display("FAIL tile_boot got %b want 1", boot_ok); end
        tile_x = 4'd3; tile_y = 3'd2; tile_ready = 1'b1;
        pump(1, 50);
        tile_x = 4'd7; tile_y = 3'd5;
        pump(5000, 8000);
        hdr = '{9'h12A, 9'h000, 9'h060, 9'h000, 9'h07F, 9'h12B, 9'h000, 9'h040, 9'h000, 9'h05F, 9'h12C};
        check_tile("t32", hdr, 2048);
    endtask

    task automatic test_last_row();
        logic [8:0] hdr [11];
        hard_reset(); fill_rom(); rom[0] = 9'h1FC;
        boot(20);
        tile_x = 4'd0; tile_y = 3'd7; tile_ready = 1'b1;
        pump(5000, 8000);
        hdr = '{9'h12A, 9'h000, 9'h000, 9'h000, 9'h01F, 9'h12B, 9'h000, 9'h0E0, 9'h000, 9'h0EF, 9'h12C};
        check_tile("t07", hdr, 1024);
    endtask

    task automatic test_back_to_back_stall();
        logic [8:0] ref_d;
        logic [9:0] ref_a;
        int bytes, errs, stall_err;
        hard_reset(); fill_rom(); rom[0] = 9'h1FC;
        boot(20);
        tile_x = 4'd1; tile_y = 3'd0; tile_ready = 1'b1;
        pump(41, 500);
        @(posedge clk); #1;
        cmd_pull = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ref_d = cmd_data; ref_a = tile_addr;
        n_vec++; if (cmd_valid !== 1'b1 || ref_d !== 9'h0C0 || ref_a !== 10'd15) begin n_bad++; $display("FAIL stall_word got v=%b d=%h a=%0d want 1/0C0/15", cmd_valid, ref_d, ref_a); end
        stall_err = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (cmd_data !== ref_d || tile_addr !== ref_a || cmd_valid !== 1'b1) stall_err++;
        end
        n_vec++; if (stall_err != 0) begin n_bad++; $display("FAIL stall_hold got %0d changes want 0", stall_err); end
        pump(5000, 8000);
        scan_pixels(bytes, errs);
        n_vec++; if (!saw_next || bytes != 2048 || errs != 0) begin n_bad++; $display("FAIL stall_resume got next=%b bytes=%0d bad=%0d want 1/2048/0", saw_next, bytes, errs); end
    endtask

    task automatic test_reset_mid_tile();
        hard_reset(); fill_rom(); rom[0] = 9'h1FD; rom[1] = 9'h1FC;
        boot(20);
        tile_x = 4'd2; tile_y = 3'd1; tile_ready = 1'b1;
        pump(20, 200);
        n_vec++; if (tile_addr === 10'd0) begin n_bad++; $display("FAIL mid_setup got addr=%0d want nonzero", tile_addr); end
        rst = 1'b1;
        #2;
        n_vec++; if (cmd_data !== 9'h100 || cmd_valid !== 1'b0 || tile_addr !== 10'd0 || tile_next !== 1'b0) begin n_bad++; $display("FAIL mid_rst_bus got d=%h v=%b a=%0d n=%b want 100/0/0/0", cmd_data, cmd_valid, tile_addr, tile_next); end
        n_vec++; if (lcd_rst !== 1'b0 || init_done !== 1'b0 || init_addr !== 7'd0) begin n_bad++; $display("FAIL mid_rst_init got rst=%b done=%b addr=%0d want 0/0/0", lcd_rst, init_done, init_addr); end
        tile_ready = 1'b0;
        @(posedge clk); #1;
        boot(20);
        n_vec++; if (boot_ok !== 1'b1 || lcd_rst !== 1'b1) begin n_bad++; $display("FAIL mid_replay got done=%b lcd_rst=%b want 1/1", boot_ok, lcd_rst); end
    endtask

`ifdef LCD_TE_SYNC_EN
    task automatic test_te_sync();
        int c, te_err;
        hard_reset(); fill_rom(); rom[0] = 9'h1FC;
        boot(20);
        cmd_pull = 1'b0; tile_x = 4'd0; tile_y = 3'd0; tile_ready = 1'b1;
        te_err = 0;
        repeat (20) begin @(posedge clk); #1; if (cmd_valid) te_err++; end
        n_vec++; if (te_err != 0) begin n_bad++; $display("FAIL te_hold got %0d valid cycles want 0", te_err); end
        lcd_te = 1'b1;
        c = 0;
        while (!cmd_valid && c < 10) begin @(posedge clk); #1; c++; end
        n_vec++; if (cmd_valid !== 1'b1 || c > 4 || cmd_data !== 9'h12A) begin n_bad++; $display("FAIL te_start got v=%b cyc=%0d d=%h want 1/<=4/12A", cmd_valid, c, cmd_data); end
        lcd_te = 1'b0; tile_ready = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_script();
        test_zero_delay();
        test_wrap_and_ready();
        test_tile_window();
        test_last_row();
        test_back_to_back_stall();
        test_reset_mid_tile();
`ifdef LCD_TE_SYNC_EN
        test_te_sync();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
